// File: rtl/hazard_ctrl_if.sv
// Hazard and sequencing controller for the RV32IF 5-stage pipeline.
// Combinational forwarding and load-use detection for the integer and FP
// register files, plus a two-state scheduler that holds E for the fixed
// latency of FDIV.S / FSQRT.S.
module hazard_ctrl_if #(
  parameter int DIV_CYC  = 16,
  parameter int SQRT_CYC = 24,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D_i,
  input  logic [4:0] Rs2D_i,
  input  logic [4:0] Rs1D_f,
  input  logic [4:0] Rs2D_f,
  input  logic [4:0] Rs1E_i,
  input  logic [4:0] Rs2E_i,
  input  logic [4:0] Rs1E_f,
  input  logic [4:0] Rs2E_f,
  input  logic [4:0] RdE_i,
  input  logic [4:0] RdE_f,
  input  logic [4:0] RdM_i,
  input  logic [4:0] RdM_f,
  input  logic [4:0] RdW_i,
  input  logic [4:0] RdW_f,
  input  logic       RegWriteM_i,
  input  logic       RegWriteW_i,
  input  logic       RegWriteM_f,
  input  logic       RegWriteW_f,
  input  logic       LoadE_i,
  input  logic       LoadE_f,
  input  logic       PCSrcE,
  input  logic       FpLongE,
  input  logic       FpSqrtE,
  output logic [1:0] ForwardAE_i,
  output logic [1:0] ForwardBE_i,
  output logic [1:0] ForwardAE_f,
  output logic [1:0] ForwardBE_f,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FpBusy,
  output logic       FpDone
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC - 2);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_CYC - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lw_stall;
  logic             fp_stall;

  // M-stage match wins over W; x0 never forwards on the integer path.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       we_m,
                                         input logic [4:0] rd_w,
                                         input logic       we_w,
                                         input logic       int_path);
    logic zero_block;
    zero_block = int_path && (rs == 5'd0);
    if (we_m && (rs == rd_m) && !zero_block)      return 2'b10;
    else if (we_w && (rs == rd_w) && !zero_block) return 2'b01;
    else                                          return 2'b00;
  endfunction

  // Operand forwarding selects for both register files.
  always_comb begin
    ForwardAE_i = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, 1'b1);
    ForwardBE_i = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, 1'b1);
    ForwardAE_f = fwd_sel(Rs1E_f, RdM_f, RegWriteM_f, RdW_f, RegWriteW_f, 1'b0);
    ForwardBE_f = fwd_sel(Rs2E_f, RdM_f, RegWriteM_f, RdW_f, RegWriteW_f, 1'b0);
  end

  // Load-use hazard and multi-cycle FP hold, combined into pipeline controls.
  always_comb begin
    lw_stall = (LoadE_i && (RdE_i != 5'd0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i))) ||
               (LoadE_f && ((RdE_f == Rs1D_f) || (RdE_f == Rs2D_f)));
    fp_stall = ((state == IDLE) && FpLongE) || ((state == BUSY) && (cnt != '0));
    FpBusy   = (state == BUSY);
    FpDone   = (state == BUSY) && (cnt == '0);
    StallF   = lw_stall || fp_stall;
    StallD   = lw_stall || fp_stall;
    StallE   = fp_stall;
    FlushM   = fp_stall;
    FlushD   = PCSrcE && !fp_stall;
    FlushE   = (lw_stall || PCSrcE) && !fp_stall;
  end

  // Latency scheduler: the first E cycle is spent in IDLE, so the counter
  // is loaded with N-2 and the release cycle is BUSY with cnt==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (FpLongE) begin
            cnt   <= FpSqrtE ? SQRT_LOAD : DIV_LOAD;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_if.sv
// Self-checking bench for hazard_ctrl_if: a behavioural reference model
// pushes expected outputs into a scoreboard queue each cycle, and the DUT
// outputs sampled on the falling edge are compared against the popped entry.
module tb_hazard_ctrl_if;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D_i, Rs2D_i, Rs1D_f, Rs2D_f;
  logic [4:0] Rs1E_i, Rs2E_i, Rs1E_f, Rs2E_f;
  logic [4:0] RdE_i, RdE_f, RdM_i, RdM_f, RdW_i, RdW_f;
  logic       RegWriteM_i, RegWriteW_i, RegWriteM_f, RegWriteW_f;
  logic       LoadE_i, LoadE_f, PCSrcE, FpLongE, FpSqrtE;
  logic [1:0] ForwardAE_i, ForwardBE_i, ForwardAE_f, ForwardBE_f;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, FpBusy, FpDone;

  hazard_ctrl_if #(.DIV_CYC(16), .SQRT_CYC(24), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1D_f(Rs1D_f), .Rs2D_f(Rs2D_f),
    .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i), .Rs1E_f(Rs1E_f), .Rs2E_f(Rs2E_f),
    .RdE_i(RdE_i), .RdE_f(RdE_f), .RdM_i(RdM_i), .RdM_f(RdM_f),
    .RdW_i(RdW_i), .RdW_f(RdW_f),
    .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .RegWriteM_f(RegWriteM_f), .RegWriteW_f(RegWriteW_f),
    .LoadE_i(LoadE_i), .LoadE_f(LoadE_f), .PCSrcE(PCSrcE),
    .FpLongE(FpLongE), .FpSqrtE(FpSqrtE),
    .ForwardAE_i(ForwardAE_i), .ForwardBE_i(ForwardBE_i),
    .ForwardAE_f(ForwardAE_f), .ForwardBE_f(ForwardBE_f),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .FpBusy(FpBusy), .FpDone(FpDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] fwd;
    logic [7:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model state: m_left = E cycles still to go including this one
  logic m_busy;
  int   m_left;
  logic n_busy;
  int   n_left;
  int   stall_cnt, done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                       input logic wem, input logic [4:0] rdw,
                                       input logic wew, input logic is_int);
    if (is_int && rs == 5'd0) return 2'b00;
    if (wem && rs == rdm)     return 2'b10;
    if (wew && rs == rdw)     return 2'b01;
    return 2'b00;
  endfunction

  // Build the expected outputs for the current inputs and model state.
  function automatic exp_t model_eval();
    exp_t e;
    logic lw, fps, done;
    lw = (LoadE_i && RdE_i != 5'd0 && (RdE_i == Rs1D_i || RdE_i == Rs2D_i)) ||
         (LoadE_f && (RdE_f == Rs1D_f || RdE_f == Rs2D_f));
    if (!m_busy) begin
      fps  = FpLongE;
      done = 1'b0;
    end else begin
      fps  = (m_left != 1);
      done = (m_left == 1);
    end
    e.fwd = {m_fwd(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, 1'b1),
             m_fwd(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, 1'b1),
             m_fwd(Rs1E_f, RdM_f, RegWriteM_f, RdW_f, RegWriteW_f, 1'b0),
             m_fwd(Rs2E_f, RdM_f, RegWriteM_f, RdW_f, RegWriteW_f, 1'b0)};
    e.ctl = {lw | fps, lw | fps, fps, PCSrcE & ~fps, (lw | PCSrcE) & ~fps,
             fps, m_busy, done};
    return e;
  endfunction

  // One clock: predict, compare at the falling edge, advance the model.
  task automatic cyc(input int n);
    exp_t e, p;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reset) begin
        m_busy = 1'b0;
        m_left = 0;
      end
      exp_q.push_back(model_eval());
      if (!m_busy && FpLongE) begin
        n_busy = 1'b1;
        n_left = (FpSqrtE ? 24 : 16) - 1;
      end else if (m_busy) begin
        n_busy = (m_left != 1);
        n_left = m_left - 1;
      end else begin
        n_busy = 1'b0;
        n_left = 0;
      end
      p = exp_q.pop_front();
      check("forward", 32'({ForwardAE_i, ForwardBE_i, ForwardAE_f, ForwardBE_f}), 32'(p.fwd));
      check("control", 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, FpBusy, FpDone}),
            32'(p.ctl));
      if (StallE) stall_cnt++;
      if (FpDone) done_cnt++;
      @(posedge clk);
      if (reset) begin
        m_busy = 1'b0;
        m_left = 0;
      end else begin
        m_busy = n_busy;
        m_left = n_left;
      end
      #1;
    end
  endtask

  task automatic idle_inputs();
    {Rs1D_i, Rs2D_i, Rs1D_f, Rs2D_f} = '0;
    {Rs1E_i, Rs2E_i, Rs1E_f, Rs2E_f} = '0;
    {RdE_i, RdE_f, RdM_i, RdM_f, RdW_i, RdW_f} = '0;
    {RegWriteM_i, RegWriteW_i, RegWriteM_f, RegWriteW_f} = '0;
    {LoadE_i, LoadE_f, PCSrcE, FpLongE, FpSqrtE} = '0;
  endtask

  initial begin
    m_busy = 1'b0;
    m_left = 0;
    stall_cnt = 0;
    done_cnt = 0;
    reset = 1'b1;
    idle_inputs();
    cyc(2);
    check("reset_outputs", 32'({ForwardAE_i, ForwardBE_i, ForwardAE_f, ForwardBE_f,
          StallF, StallD, StallE, FlushD, FlushE, FlushM, FpBusy, FpDone}), 32'h0);
    reset = 1'b0;
    cyc(1);

    // M over W priority, then W-only forward
    RdM_i = 5'd5; RdW_i = 5'd5; RegWriteM_i = 1'b1; RegWriteW_i = 1'b1; Rs1E_i = 5'd5;
    cyc(1);
    check("fwdA_i_M", 32'(ForwardAE_i), 32'(2'b10));
    RegWriteM_i = 1'b0;
    cyc(1);
    check("fwdA_i_W", 32'(ForwardAE_i), 32'(2'b01));

    // x0 never forwards, f0 does
    idle_inputs();
    Rs2E_i = 5'd0; RdM_i = 5'd0; RegWriteM_i = 1'b1;
    Rs2E_f = 5'd0; RdM_f = 5'd0; RegWriteM_f = 1'b1;
    cyc(1);
    check("fwdB_i_x0", 32'(ForwardBE_i), 32'(2'b00));
    check("fwdB_f_f0", 32'(ForwardBE_f), 32'(2'b10));

    // load-use on the integer file, then the same with x0 destination
    idle_inputs();
    LoadE_i = 1'b1; RdE_i = 5'd7; Rs2D_i = 5'd7;
    cyc(1);
    check("lw_stall", 32'({StallF, StallD, FlushE}), 32'(3'b111));
    RdE_i = 5'd0; Rs2D_i = 5'd0;
    cyc(1);
    check("lw_x0", 32'({StallF, StallD, FlushE}), 32'(3'b000));

    // taken branch
    idle_inputs();
    PCSrcE = 1'b1;
    cyc(1);
    check("branch", 32'({FlushD, FlushE, StallF}), 32'(3'b110));

    // FDIV.S: 15 stall cycles then one done pulse; branch pulse mid-op
    idle_inputs();
    stall_cnt = 0; done_cnt = 0;
    FpLongE = 1'b1; FpSqrtE = 1'b0;
    cyc(7);
    PCSrcE = 1'b1;
    cyc(1);
    check("no_flushE_in_op", 32'({FlushE, FlushD}), 32'(2'b00));
    PCSrcE = 1'b0;
    cyc(8);
    FpLongE = 1'b0;
    cyc(2);
    check("div_stall_cycles", 32'(stall_cnt), 32'd15);
    check("div_done_pulses", 32'(done_cnt), 32'd1);

    // FSQRT.S abandoned by reset on its fifth cycle
    FpLongE = 1'b1; FpSqrtE = 1'b1;
    cyc(4);
    reset = 1'b1; FpLongE = 1'b0; FpSqrtE = 1'b0;
    cyc(1);
    check("reset_midop", 32'({FpBusy, StallF, StallE, FlushM}), 32'(4'b0000));
    reset = 1'b0;
    cyc(1);
    stall_cnt = 0; done_cnt = 0;
    FpLongE = 1'b1;
    cyc(16);
    FpLongE = 1'b0;
    cyc(2);
    check("div_after_reset_stalls", 32'(stall_cnt), 32'd15);
    check("div_after_reset_done", 32'(done_cnt), 32'd1);

    // random traffic with small register numbers to provoke matches
    for (int k = 0; k < 400; k++) begin
      Rs1D_i = 5'($urandom_range(0, 3)); Rs2D_i = 5'($urandom_range(0, 3));
      Rs1D_f = 5'($urandom_range(0, 3)); Rs2D_f = 5'($urandom_range(0, 3));
      Rs1E_i = 5'($urandom_range(0, 3)); Rs2E_i = 5'($urandom_range(0, 3));
      Rs1E_f = 5'($urandom_range(0, 3)); Rs2E_f = 5'($urandom_range(0, 3));
      RdE_i = 5'($urandom_range(0, 3)); RdE_f = 5'($urandom_range(0, 3));
      RdM_i = 5'($urandom_range(0, 3)); RdM_f = 5'($urandom_range(0, 3));
      RdW_i = 5'($urandom_range(0, 3)); RdW_f = 5'($urandom_range(0, 3));
      {RegWriteM_i, RegWriteW_i, RegWriteM_f, RegWriteW_f} = 4'($urandom);
      LoadE_i = 1'($urandom); LoadE_f = 1'($urandom);
      FpLongE = ($urandom_range(0, 15) == 0);
      FpSqrtE = 1'($urandom);
      PCSrcE  = FpLongE ? 1'b0 : ($urandom_range(0, 3) == 0);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
